// File: rtl/axi_lite_slave_regs_if.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs_if
// Purpose : AXI4-Lite bus bundle for the register slave. Clock and reset are
//           not part of the bundle; they stay plain ports on the modules.
// Ports   : write address (AWADDR/AWVALID/AWREADY), write data
//           (WDATA/WSTRB/WVALID/WREADY), write response (BRESP/BVALID/BREADY),
//           read address (ARADDR/ARVALID/ARREADY), read data
//           (RDATA/RRESP/RVALID/RREADY).
// Modports: master drives VALIDs/addresses/data and the response READYs;
//           slave drives the address/data READYs and the responses.
// ---------------------------------------------------------------------------
interface axi_lite_slave_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
// Purpose : AXI4-Lite slave with a small register file.
//             reg 0 : read-only ID 32'hA11E_0001
//             reg 1 : read-only count of OKAY writes (wraps)
//             reg 2..C_NUM_REGS-1 : read/write; reg 2 also drives ctrl_out
//           Out-of-map accesses and writes to reg 0/1 answer SLVERR.
// Ports   : S_AXI_ACLK    - clock, rising edge
//           S_AXI_ARESETN - synchronous active-low reset
//           s_axi         - AXI4-Lite bus (slave modport)
//           ctrl_out      - live copy of register 2
// Options : define AXI_LITE_SLAVE_REGS_WSTRB_EN to honour WSTRB byte lanes;
//           otherwise every write replaces the full word.
// Notes   : AWREADY/WREADY are registered, so a write handshakes one cycle
//           after both VALIDs are seen; with BREADY high this gives one write
//           every three cycles. Read and write paths are fully independent.
// ---------------------------------------------------------------------------
module axi_lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR = 32'h0000_001F,
  parameter int C_NUM_REGS = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  axi_lite_slave_regs_if.slave          s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_out
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [DW-1:0] ID_VALUE    = 32'hA11E_0001;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Word index of a byte address relative to the base of the map.
  function automatic logic [AW-1:0] word_index(input logic [AW-1:0] addr);
    word_index = (addr - C_BASEADDR) >> 2'd2;
  endfunction

  // Address inside [C_BASEADDR, C_HIGHADDR] and backed by a register. The
  // offset form wraps addresses below the base to huge values, so one
  // unsigned compare covers both bounds.
  function automatic logic addr_in_map(input logic [AW-1:0] addr);
    addr_in_map = ((addr - C_BASEADDR) <= (C_HIGHADDR - C_BASEADDR)) &&
                  (word_index(addr) < AW'(C_NUM_REGS));
  endfunction

`ifdef AXI_LITE_SLAVE_REGS_WSTRB_EN
  // Expand byte strobes into a bit mask.
  function automatic logic [DW-1:0] strb_to_mask(input logic [SW-1:0] strb);
    strb_to_mask = {DW{1'b0}};
    for (int b = 0; b < SW; b++) begin
      strb_to_mask[b*8 +: 8] = {8{strb[b]}};
    end
  endfunction
`endif

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic          awready_q, awready_d;
  logic          bvalid_q,  bvalid_d;
  logic [1:0]    bresp_q,   bresp_d;
  logic          arready_q, arready_d;
  logic          rvalid_q,  rvalid_d;
  logic [1:0]    rresp_q,   rresp_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [DW-1:0] wr_count_q, wr_count_d;
  logic [DW-1:0] regs_q [2:C_NUM_REGS-1];
  logic [DW-1:0] regs_d [2:C_NUM_REGS-1];

  logic [AW-1:0] aw_word_s;
  logic [AW-1:0] ar_word_s;
  logic          aw_ok_s;
  logic          ar_ok_s;
  logic          w_hs_s;
  logic          w_commit_s;
  logic [DW-1:0] wr_mask_s;
  logic [DW-1:0] rd_word_s;

  assign aw_word_s = word_index(s_axi.S_AXI_AWADDR);
  assign ar_word_s = word_index(s_axi.S_AXI_ARADDR);
  // Writes are only legal to the read/write part of the map.
  assign aw_ok_s   = addr_in_map(s_axi.S_AXI_AWADDR) && (aw_word_s >= AW'(2));
  assign ar_ok_s   = addr_in_map(s_axi.S_AXI_ARADDR);
  // READY is only ever high in W_IDLE, so this is the single commit edge.
  assign w_hs_s     = awready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign w_commit_s = w_hs_s && aw_ok_s;

`ifdef AXI_LITE_SLAVE_REGS_WSTRB_EN
  assign wr_mask_s = strb_to_mask(s_axi.S_AXI_WSTRB);
`else
  assign wr_mask_s = {DW{1'b1}};
  logic unused_wstrb_s;
  assign unused_wstrb_s = ^s_axi.S_AXI_WSTRB;
`endif

  // Write FSM: hold READY off until both channels are valid, then respond.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_hs_s) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = aw_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
          awready_d = 1'b1;
        end else begin
          awready_d = 1'b0;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Register file update and OKAY-write counter.
  always_comb begin
    wr_count_d = w_commit_s ? (wr_count_q + DW'(1'b1)) : wr_count_q;
    for (int i = 2; i < C_NUM_REGS; i++) begin
      regs_d[i] = (w_commit_s && (aw_word_s == AW'(i))) ?
                  ((regs_q[i] & ~wr_mask_s) | (s_axi.S_AXI_WDATA & wr_mask_s)) :
                  regs_q[i];
    end
  end

  // Read data mux: exactly one term matches a valid index.
  always_comb begin
    rd_word_s = (ar_word_s == AW'(0)) ? ID_VALUE :
                (ar_word_s == AW'(1)) ? wr_count_q : {DW{1'b0}};
    for (int i = 2; i < C_NUM_REGS; i++) begin
      rd_word_s = rd_word_s | ((ar_word_s == AW'(i)) ? regs_q[i] : {DW{1'b0}});
    end
  end

  // Read FSM: capture data on the AR handshake, hold it until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID && arready_q) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = ar_ok_s ? RESP_OKAY : RESP_SLVERR;
          rdata_d   = ar_ok_s ? rd_word_s : {DW{1'b0}};
        end else begin
          // Also raises ARREADY on the first edge after reset release.
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end else begin
          arready_d = 1'b0;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
        arready_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= {DW{1'b0}};
      wr_count_q <= {DW{1'b0}};
      for (int i = 2; i < C_NUM_REGS; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
      regs_q     <= regs_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign ctrl_out            = regs_q[2];

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
// Purpose : directed self-checking bench for axi_lite_slave_regs. Inputs are
//           driven and outputs sampled on the falling edge; the DUT acts on
//           the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

  localparam int TMO = 20;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_out;
  int          assert_cnt;
  int          fail_cnt;

  axi_lite_slave_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) bus ();

  axi_lite_slave_regs dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus.slave),
    .ctrl_out     (ctrl_out)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present AW and W together and wait for the handshake edge to pass.
  task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (bus.S_AXI_AWREADY !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_val("wr_hs_timeout", 32'(n < TMO), 32'd1);
    check_val("wready_with_awready", 32'(bus.S_AXI_WREADY), 32'd1);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int n;
    start_write(addr, data, strb);
    n = 0;
    while (bus.S_AXI_BVALID !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_val("bvalid_timeout", 32'(n < TMO), 32'd1);
    resp = bus.S_AXI_BRESP;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (bus.S_AXI_ARREADY !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_val("rd_hs_timeout", 32'(n < TMO), 32'd1);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    // Data must be valid exactly one cycle after the AR handshake.
    check_val("rvalid_latency", 32'(bus.S_AXI_RVALID), 32'd1);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check_val({tag, "_rdata"}, d, exp_data);
    check_val({tag, "_rresp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic write_expect(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, strb, r);
    check_val({tag, "_bresp"}, 32'(r), 32'(exp_resp));
  endtask

  logic [31:0] exp_0c_a;
  logic [31:0] exp_0c_b;
  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic [1:0]  wr_r;

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst_n      = 1'b0;
    bus.S_AXI_AWADDR  = 32'h0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = 32'h0;
    bus.S_AXI_WSTRB   = 4'h0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = 32'h0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;

`ifdef AXI_LITE_SLAVE_REGS_WSTRB_EN
    exp_0c_a = 32'h0022_0044;
    exp_0c_b = 32'h0022_0044;
`else
    exp_0c_a = 32'h1122_3344;
    exp_0c_b = 32'hFFFF_FFFF;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check_val("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check_val("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check_val("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check_val("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    check_val("rst_ctrl",    ctrl_out,               32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("arready_after_release", 32'(bus.S_AXI_ARREADY), 32'd1);

    // ID register.
    read_expect("id", 32'h00, 32'hA11E_0001, 2'b00);

    // Basic write then read back, counter = 1.
    write_expect("wr08", 32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00);
    check_val("ctrl_out_beef", ctrl_out, 32'hDEAD_BEEF);
    read_expect("rd08", 32'h08, 32'hDEAD_BEEF, 2'b00);
    read_expect("cnt1", 32'h04, 32'd1, 2'b00);

    // AW ahead of W: no READY until both valid; BVALID held under BREADY=0.
    bus.S_AXI_BREADY  = 1'b0;
    @(negedge clk);
    bus.S_AXI_AWADDR  = 32'h10;
    bus.S_AXI_WDATA   = 32'h0000_5A5A;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("aw_only_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      check_val("aw_only_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    end
    bus.S_AXI_WVALID = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.S_AXI_AWREADY !== 1'b1 && n < TMO) begin
        @(negedge clk);
        n++;
      end
      check_val("late_w_hs_timeout", 32'(n < TMO), 32'd1);
    end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_val("bvalid_held", 32'(bus.S_AXI_BVALID), 32'd1);
      check_val("bresp_held",  32'(bus.S_AXI_BRESP),  32'd0);
      @(negedge clk);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    check_val("bvalid_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    read_expect("rd10", 32'h10, 32'h0000_5A5A, 2'b00);
    read_expect("cnt2", 32'h04, 32'd2, 2'b00);

    // Error cases: writes to RO registers, out-of-map reads.
    write_expect("wr00", 32'h00, 32'h1234_5678, 4'hF, 2'b10);
    write_expect("wr04", 32'h04, 32'h1234_5678, 4'hF, 2'b10);
    write_expect("wr40", 32'h40, 32'h1234_5678, 4'hF, 2'b10);
    read_expect("rd40", 32'h40, 32'h0, 2'b10);
    read_expect("rd20", 32'h20, 32'h0, 2'b10);
    read_expect("id_after_err", 32'h00, 32'hA11E_0001, 2'b00);
    read_expect("cnt_after_err", 32'h04, 32'd2, 2'b00);

    // Byte strobes (behaviour depends on build option).
    write_expect("wr0c", 32'h0C, 32'h1122_3344, 4'b0101, 2'b00);
    read_expect("rd0c", 32'h0C, exp_0c_a, 2'b00);
    write_expect("wr0c_nostrb", 32'h0C, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    read_expect("rd0c_nostrb", 32'h0C, exp_0c_b, 2'b00);
    read_expect("cnt4", 32'h04, 32'd4, 2'b00);

    // Read and write to the same register on the same edge: old value.
    fork
      axi_write(32'h08, 32'h0BAD_CAFE, 4'hF, wr_r);
      begin
        @(negedge clk);
        axi_read(32'h08, rd_d, rd_r);
      end
    join
    check_val("same_edge_bresp", 32'(wr_r), 32'd0);
    check_val("same_edge_rdata", rd_d, 32'hDEAD_BEEF);
    read_expect("rd08_new", 32'h08, 32'h0BAD_CAFE, 2'b00);
    read_expect("cnt5", 32'h04, 32'd5, 2'b00);

    // Reset while a write response is pending.
    bus.S_AXI_BREADY = 1'b0;
    start_write(32'h08, 32'h1234_5678, 4'hF);
    check_val("pend_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_mid_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check_val("rst_mid_ctrl",   ctrl_out,               32'd0);
    rst_n = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    read_expect("id_after_rst", 32'h00, 32'hA11E_0001, 2'b00);
    read_expect("cnt_after_rst", 32'h04, 32'd0, 2'b00);
    read_expect("rd08_after_rst", 32'h08, 32'd0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter C_BASEADDR, default 32'h0000_0000, first byte address decoded.
REQ-004 SHALL have parameter C_HIGHADDR, default 32'h0000_001F, last byte address decoded.
REQ-005 SHALL have parameter C_NUM_REGS, default 8, register count, range 3..16.
REQ-006 SHALL have S_AXI_ACLK, in, 1, the single clock; all logic is on the rising edge.
REQ-007 SHALL have S_AXI_ARESETN, in, 1, reset, synchronous, active-low.
REQ-008 SHALL have S_AXI_AWADDR in ADDR_W, S_AXI_AWVALID in 1, and S_AXI_AWREADY out 1.
REQ-009 SHALL have S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, and S_AXI_WREADY out 1.
REQ-010 SHALL have S_AXI_BRESP out 2, S_AXI_BVALID out 1, and S_AXI_BREADY in 1.
REQ-011 SHALL have S_AXI_ARADDR in ADDR_W, S_AXI_ARVALID in 1, and S_AXI_ARREADY out 1.
REQ-012 SHALL have S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, and S_AXI_RREADY in 1.
REQ-013 SHALL have ctrl_out, out, 32, which continuously reflects register 2.

Function
REQ-014 Decode SHALL use idx = (addr - C_BASEADDR) >> 2.
REQ-015 An access SHALL be valid when C_BASEADDR <= addr <= C_HIGHADDR and idx < C_NUM_REGS; otherwise the response SHALL be SLVERR (2'b10).
REQ-016 Register 0 SHALL be read-only, value 32'hA11E_0001.
REQ-017 Register 1 SHALL be a read-only count of OKAY writes that wraps from 32'hFFFF_FFFF to 0.
REQ-018 Registers 2..C_NUM_REGS-1 SHALL be read/write.
REQ-019 A write to register 0 or 1 SHALL return SLVERR with no state change; the write counter SHALL NOT increment.
REQ-020 The write FSM SHALL have states W_IDLE and W_RESP.
REQ-021 In W_IDLE with AWVALID and WVALID both high, the block SHALL assert AWREADY and WREADY together for exactly one cycle, commit the write on that edge, and enter W_RESP next cycle with BVALID=1.
REQ-022 AWVALID without WVALID, or WVALID without AWVALID, SHALL be held off: both READY signals stay 0.
REQ-023 In W_RESP, BVALID and BRESP SHALL hold until BREADY=1, then the FSM SHALL return to W_IDLE with BVALID=0 the next cycle; back-to-back throughput is 1 write per 3 cycles when BREADY is tied high.
REQ-024 The read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-025 An ARVALID&&ARREADY handshake SHALL register RDATA/RRESP and raise RVALID the next cycle, giving 1-cycle latency.
REQ-026 RVALID, RDATA, and RRESP SHALL hold stable until RREADY=1, then return to R_IDLE.
REQ-027 RDATA SHALL be 0 on SLVERR.
REQ-028 The read and write FSMs SHALL be independent.
REQ-029 A read and a write to the same register that handshake on the same edge SHALL return the pre-write value.
REQ-030 The write counter SHALL increment on the commit edge.
REQ-031 BRESP and RRESP SHALL be OKAY (2'b00) for valid accesses.

Reset
REQ-032 While S_AXI_ARESETN=0 at an edge, the block SHALL force: both FSMs to IDLE; AWREADY=WREADY=BVALID=RVALID=0; ARREADY=0; BRESP=RRESP=0; RDATA=0; registers 1..N-1=0; ctrl_out=0.
REQ-033 ARREADY SHALL rise on the first edge after reset release.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no response and no further register update.

Configuration
REQ-035 Macro AXI_LITE_SLAVE_REGS_WSTRB_EN defined: only byte lanes with WSTRB[i]=1 SHALL be updated; WSTRB=4'b0000 to a valid RW register SHALL return OKAY, leave data unchanged, and increment the counter.
REQ-036 Macro AXI_LITE_SLAVE_REGS_WSTRB_EN undefined: WSTRB SHALL be ignored and the full word written.

Verification
REQ-037 Reset then read addr 0x00 -> RDATA=32'hA11E_0001, RRESP=OKAY, RVALID exactly 1 cycle after the AR handshake.
REQ-038 Write 0x08 = 32'hDEAD_BEEF, then read 0x08 and 0x04 -> ctrl_out=32'hDEAD_BEEF, BRESP=OKAY, reg1 reads 1.
REQ-039 AWVALID raised 3 cycles before WVALID -> no READY until both valid; a single write commits; BVALID is held 4 cycles under BREADY=0 with BRESP stable.
REQ-040 Write 0x00 and read 0x40 -> both SLVERR, reg0 unchanged, reg1 unchanged, RDATA=0.
REQ-041 With the macro, write 0x0C = 32'h1122_3344 with WSTRB=4'b0101 over prior 0 -> reads 32'h0022_0044; without the macro -> reads 32'h1122_3344.
REQ-042 Assert reset while BVALID=1 -> BVALID=0 next edge, reg2=0, reg1=0, and a subsequent read of 0x00 works normally.
